// File: rtl/xc_aessub_seq_if.sv
// Execute-stage dispatch bundle for the multi-cycle AES SubBytes unit.
// The master drives the request side; the slave returns a one-cycle ready pulse with the result.
interface xc_aessub_seq_if;
  logic        flush;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        enc;
  logic        rot;
  logic        ready;
  logic [31:0] result;

  modport master (
    output flush, valid, rs1, rs2, enc, rot,
    input  ready, result
  );

  modport slave (
    input  flush, valid, rs1, rs2, enc, rot,
    output ready, result
  );
endinterface

// File: rtl/xc_aessub_seq.sv
// Multi-cycle AES SubBytes unit: four gathered bytes go through SBOXES S-box
// lanes per cycle, and the unit returns a registered 32-bit result with a one-cycle ready pulse.
module xc_aessub_sbox (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    logic [15:0] d;
    d = {x, x} << s;
    return d[15:8];
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre_s;
  logic [7:0] mid_s;

  // One shared field inverter: the affine step sits before it for decrypt, after it for encrypt.
  always_comb begin
    pre_s = din;
    dout  = 8'h00;
    if (inv) begin
      pre_s = aff_inv(din);
    end else begin
      pre_s = din;
    end
    mid_s = gf_inv(pre_s);
    if (inv) begin
      dout = mid_s;
    end else begin
      dout = aff_fwd(mid_s);
    end
  end

endmodule

module xc_aessub_seq #(
  parameter int SBOXES = 4
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  xc_aessub_seq_if.slave   bus
);

  if (!(SBOXES == 1 || SBOXES == 2 || SBOXES == 4)) begin : g_bad_sboxes
    $error("xc_aessub_seq: SBOXES must be 1, 2 or 4");
  end

  localparam int         N        = 4 / SBOXES;
  localparam logic [1:0] CNT_LAST = 2'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [1:0]      cnt_r;
  logic [3:0][7:0] ops_r;
  logic [3:0][7:0] res_r;
  logic            enc_r;
  logic            rot_r;
  logic            ready_r;
  logic [31:0]     result_r;

  logic [1:0]      lane_s   [SBOXES];
  logic [7:0]      sin_s    [SBOXES];
  logic [7:0]      sout_s   [SBOXES];
  logic [3:0][7:0] next_res_s;
  logic [31:0]     final_s;

  for (genvar i = 0; i < SBOXES; i++) begin : g_sbox
    assign lane_s[i] = 2'(cnt_r * 2'(SBOXES) + 2'(i));
    assign sin_s[i]  = ops_r[lane_s[i]];

    xc_aessub_sbox u_sbox (
      .din  (sin_s[i]),
      .inv  (!enc_r),
      .dout (sout_s[i])
    );
  end

  // Merge this cycle's S-box outputs into their result lanes and apply the optional rotate.
  always_comb begin
    next_res_s = res_r;
    for (int i = 0; i < SBOXES; i++) begin
      next_res_s[lane_s[i]] = sout_s[i];
    end
    if (rot_r) begin
      final_s = {next_res_s[2:0], next_res_s[3]};
    end else begin
      final_s = next_res_s;
    end
  end

  // Control FSM and datapath registers; ready/result are loaded only on entry to DONE.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r  <= IDLE;
      cnt_r    <= 2'd0;
      ops_r    <= 32'h0000_0000;
      res_r    <= 32'h0000_0000;
      enc_r    <= 1'b0;
      rot_r    <= 1'b0;
      ready_r  <= 1'b0;
      result_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          ready_r  <= 1'b0;
          result_r <= 32'h0000_0000;
          cnt_r    <= 2'd0;
          if (bus.valid && !bus.flush) begin
            ops_r   <= {bus.rs2[31:24], bus.rs1[23:16], bus.rs2[15:8], bus.rs1[7:0]};
            enc_r   <= bus.enc;
            rot_r   <= bus.rot;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_r  <= IDLE;
            cnt_r    <= 2'd0;
            ready_r  <= 1'b0;
            result_r <= 32'h0000_0000;
          end else if (cnt_r == CNT_LAST) begin
            res_r    <= next_res_s;
            state_r  <= DONE;
            cnt_r    <= 2'd0;
            ready_r  <= 1'b1;
            result_r <= final_s;
          end else begin
            res_r    <= next_res_s;
            cnt_r    <= cnt_r + 2'd1;
            ready_r  <= 1'b0;
            result_r <= 32'h0000_0000;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          cnt_r    <= 2'd0;
          ready_r  <= 1'b0;
          result_r <= 32'h0000_0000;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 2'd0;
          ready_r  <= 1'b0;
          result_r <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Self-checking bench for xc_aessub_seq: one instance each at SBOXES = 1, 2 and 4,
// scoreboard queue of expected results built from a reference S-box table.
module tb_xc_aessub_seq;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic        clk = 1'b0;
  logic        g_resetn;
  logic        valid_a  [3];
  logic        flush_a  [3];
  logic        enc_a    [3];
  logic        rot_a    [3];
  logic [31:0] rs1_a    [3];
  logic [31:0] rs2_a    [3];
  logic        ready_a  [3];
  logic [31:0] result_a [3];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int SB = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    xc_aessub_seq_if bus ();
    assign bus.valid   = valid_a[g];
    assign bus.flush   = flush_a[g];
    assign bus.enc     = enc_a[g];
    assign bus.rot     = rot_a[g];
    assign bus.rs1     = rs1_a[g];
    assign bus.rs2     = rs2_a[g];
    assign ready_a[g]  = bus.ready;
    assign result_a[g] = bus.result;

    xc_aessub_seq #(.SBOXES(SB)) dut (
      .g_clk    (clk),
      .g_resetn (g_resetn),
      .bus      (bus.slave)
    );
  end

  function automatic int nof(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 256; j++) begin
      if (SBOX[j] == x) r = 8'(j);
    end
    return r;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic e, input logic r);
    logic [7:0]  in_b [4];
    logic [31:0] raw;
    in_b = '{a[7:0], b[15:8], a[23:16], b[31:24]};
    for (int i = 0; i < 4; i++) begin
      raw[8*i +: 8] = e ? SBOX[in_b[i]] : inv_sbox(in_b[i]);
    end
    return r ? {raw[23:0], raw[31:24]} : raw;
  endfunction

  task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic e, input logic r);
    valid_a[d] = v;
    rs1_a[d]   = a;
    rs2_a[d]   = b;
    enc_a[d]   = e;
    rot_a[d]   = r;
  endtask

  // One request from an idle DUT; checks latency, single pulse, result and zero gating.
  task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic e,
                       input logic r, input logic [31:0] expv, input string name,
                       output logic [31:0] obs);
    int n, first, pulses, leak;
    logic [31:0] want;
    n = nof(d);
    @(negedge clk);
    drive(d, 1'b1, a, b, e, r);
    flush_a[d] = 1'b0;
    sb.push_back(expv);
    first = 0; pulses = 0; leak = 0; obs = 32'h0;
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      if (ready_a[d] === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = k;
          obs   = result_a[d];
        end
        valid_a[d] = 1'b0;
      end else if (result_a[d] !== 32'h0) begin
        leak++;
      end
    end
    valid_a[d] = 1'b0;
    want = sb.pop_front();
    checks++;
    if (first != n + 1) begin
      failures++;
      $display("FAIL %s_latency d=%0d got=%0d want=%0d", name, d, first, n + 1);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL %s_pulses d=%0d got=%0d want=1", name, d, pulses);
    end
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s_result d=%0d got=%h want=%h", name, d, obs, want);
    end
    checks++;
    if (leak != 0) begin
      failures++;
      $display("FAIL %s_gating d=%0d got=%0d want=0", name, d, leak);
    end
  endtask

  task automatic test_reset(input int d);
    int n, seen;
    logic [31:0] obs;
    n = nof(d);
    @(negedge clk);
    drive(d, 1'b1, 32'h0053_0001, 32'hFF00_0000, 1'b1, 1'b0);
    @(negedge clk);
    g_resetn = 1'b0;
    valid_a[d] = 1'b0;
    #1;
    checks++;
    if ({ready_a[d], result_a[d]} !== 33'h0) begin
      failures++;
      $display("FAIL reset_run d=%0d got=%h want=0", d, {ready_a[d], result_a[d]});
    end
    @(negedge clk);
    g_resetn = 1'b1;
    seen = 0;
    repeat (n + 3) begin
      @(negedge clk);
      if (ready_a[d] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_discard d=%0d got=%0d want=0", d, seen);
    end
    // Reset landing in the DONE cycle must clear the visible pulse immediately.
    @(negedge clk);
    drive(d, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    seen = 0;
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      if (ready_a[d] === 1'b1) begin
        seen = 1;
        break;
      end
    end
    valid_a[d] = 1'b0;
    checks++;
    if (seen == 0) begin
      failures++;
      $display("FAIL reset_done_timeout d=%0d got=0 want=1", d);
    end else begin
      g_resetn = 1'b0;
      #1;
      if ({ready_a[d], result_a[d]} !== 33'h0) begin
        failures++;
        $display("FAIL reset_done d=%0d got=%h want=0", d, {ready_a[d], result_a[d]});
      end
      @(negedge clk);
      g_resetn = 1'b1;
    end
    do_op(d, 32'h0053_0001, 32'hFF00_0000, 1'b1, 1'b0, 32'h16ED637C, "after_reset", obs);
  endtask

  task automatic test_vectors(input int d);
    logic [31:0] obs;
    do_op(d, 32'h0, 32'h0, 1'b1, 1'b0, 32'h63636363, "zero", obs);
    do_op(d, 32'h0053_0001, 32'hFF00_0000, 1'b1, 1'b0, 32'h16ED637C, "enc_norot", obs);
    do_op(d, 32'h0053_0001, 32'hFF00_0000, 1'b1, 1'b1, 32'hED637C16, "enc_rot", obs);
    do_op(d, 32'h0063_0016, 32'h7C00_ED00, 1'b0, 1'b0, 32'h010053FF, "dec_norot", obs);
  endtask

  task automatic test_roundtrip(input int d);
    logic [31:0] a, b, fwd, back, orig;
    for (int i = 0; i < 64; i++) begin
      orig = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
      a = {8'h00, orig[23:16], 8'h00, orig[7:0]};
      b = {orig[31:24], 8'h00, orig[15:8], 8'h00};
      do_op(d, a, b, 1'b1, 1'b0, model(a, b, 1'b1, 1'b0), "rt_enc", fwd);
      a = {8'h00, fwd[23:16], 8'h00, fwd[7:0]};
      b = {fwd[31:24], 8'h00, fwd[15:8], 8'h00};
      do_op(d, a, b, 1'b0, 1'b0, orig, "rt_dec", back);
    end
  endtask

  task automatic test_flush(input int d);
    int n, seen;
    logic [31:0] obs;
    n = nof(d);
    @(negedge clk);
    drive(d, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    @(negedge clk);
    flush_a[d] = 1'b1;
    valid_a[d] = 1'b0;
    @(negedge clk);
    flush_a[d] = 1'b0;
    checks++;
    if (ready_a[d] !== 1'b0) begin
      failures++;
      $display("FAIL flush_run d=%0d got=%b want=0", d, ready_a[d]);
    end
    do_op(d, 32'h0053_0001, 32'hFF00_0000, 1'b1, 1'b0, 32'h16ED637C, "post_flush", obs);
    @(negedge clk);
    drive(d, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
    flush_a[d] = 1'b1;
    seen = 0;
    repeat (n + 3) begin
      @(negedge clk);
      if (ready_a[d] !== 1'b0) seen++;
    end
    valid_a[d] = 1'b0;
    flush_a[d] = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_idle d=%0d got=%0d want=0", d, seen);
    end
  endtask

  // Valid held across three ops; operands are scrambled while each op is in RUN.
  task automatic test_back_to_back(input int d);
    logic [31:0] oa [3] = '{32'h0011_2233, 32'hA5C3_5A3C, 32'h0063_0016};
    logic [31:0] ob [3] = '{32'h4455_6677, 32'hFFEE_0102, 32'h7C00_ED00};
    logic        oe [3] = '{1'b1, 1'b1, 1'b0};
    logic        orr[3] = '{1'b0, 1'b1, 1'b1};
    int n, idx, pulses, last, since;
    logic [31:0] want;
    n = nof(d);
    @(negedge clk);
    drive(d, 1'b1, oa[0], ob[0], oe[0], orr[0]);
    sb.push_back(model(oa[0], ob[0], oe[0], orr[0]));
    idx = 1; pulses = 0; last = -1; since = 1;
    for (int k = 1; k <= 3 * (n + 2) + 6; k++) begin
      @(negedge clk);
      if (ready_a[d] === 1'b1) begin
        pulses++;
        want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (result_a[d] !== want) begin
          failures++;
          $display("FAIL b2b_result d=%0d got=%h want=%h", d, result_a[d], want);
        end
        if (last >= 0) begin
          checks++;
          if (k - last != n + 2) begin
            failures++;
            $display("FAIL b2b_spacing d=%0d got=%0d want=%0d", d, k - last, n + 2);
          end
        end
        last = k;
        since = 0;
        if (idx < 3) begin
          drive(d, 1'b1, oa[idx], ob[idx], oe[idx], orr[idx]);
          sb.push_back(model(oa[idx], ob[idx], oe[idx], orr[idx]));
          idx++;
        end else begin
          valid_a[d] = 1'b0;
        end
      end else begin
        since++;
        if (since >= 2 && valid_a[d] === 1'b1) begin
          drive(d, 1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
        end
      end
    end
    valid_a[d] = 1'b0;
    sb.delete();
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL b2b_pulses d=%0d got=%0d want=3", d, pulses);
    end
  endtask

  initial begin
    g_resetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      flush_a[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ready_a[d], result_a[d]} !== 33'h0) begin
        failures++;
        $display("FAIL reset_state d=%0d got=%h want=0", d, {ready_a[d], result_a[d]});
      end
    end
    g_resetn = 1'b1;
    for (int d = 0; d < 3; d++) begin
      test_reset(d);
      test_vectors(d);
      test_roundtrip(d);
      test_flush(d);
      test_back_to_back(d);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
